// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with baud-select driven bit timing.
// The rx pin is synchronized, each bit is sampled at mid-period, and a
// completed frame is reported with a one-cycle rx_done (good stop bit) or
// rx_err (stop bit low) strobe.
module uart_rx_core #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16:0]          baud,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_err,
    output logic                 busy
);

    // 14 bits hold the longest bit period (10416 clocks at 4800 baud).
    localparam int CNT_W = 14;
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    logic [CNT_W-1:0]       w_period;
    logic [CNT_W-1:0]       w_half;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_period;
    logic [BIT_W-1:0]       r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_done;
    logic                   r_rx_err;
    logic                   r_busy;

    // Input synchronizer; flops reset to the idle (high) line level so a
    // reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // Baud select to bit period in clocks; unknown rates fall back to 9600.
    always_comb begin
        w_period = 14'd5208;
        case (baud)
            17'd4800:  w_period = 14'd10416;
            17'd9600:  w_period = 14'd5208;
            17'd14400: w_period = 14'd3472;
            17'd19200: w_period = 14'd2604;
            17'd38400: w_period = 14'd1302;
            17'd57600: w_period = 14'd868;
            default:   w_period = 14'd5208;
        endcase
    end

    // Half period is taken from the latched period so a mid-frame baud
    // change cannot disturb the frame in progress.
    assign w_half = r_period >> 1;

    // Receive FSM with registered data, strobes and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_rx_data <= '0;
            r_rx_done <= 1'b0;
            r_rx_err  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            r_rx_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state  <= ST_START;
                        r_cnt    <= '0;
                        r_period <= w_period;
                        r_busy   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (r_cnt == w_half - 14'd1) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        if (!w_rx_s) begin
                            r_state <= ST_DATA;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 14'd1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == r_period - 14'd1) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 14'd1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == r_period - 14'd1) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_rx_data <= r_shift;
                            r_rx_done <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                        end else begin
                            r_rx_err <= 1'b1;
                            r_state  <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 14'd1;
                    end
                end
                ST_BREAK: begin
                    // Wait out a held-low line so it is not taken as a new start.
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data = r_rx_data;
    assign rx_done = r_rx_done;
    assign rx_err  = r_rx_err;
    assign busy    = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core: frames, back-to-back, false starts
// across all baud selections, framing error with break, async reset.
module tb_uart_rx_core;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] baud;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int cyc           = 0;
    int done_cnt      = 0;
    int err_cnt       = 0;
    int viol          = 0;
    int last_done_cyc = 0;
    logic prev_done   = 1'b0;
    logic prev_err    = 1'b0;

    uart_rx_core #(.DATA_BITS(8), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .rst     (rst),
        .baud    (baud),
        .rx      (rx),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .rx_err  (rx_err),
        .busy    (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts strobes and records pulse-rule violations.
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (rx_err) err_cnt <= err_cnt + 1;
        if ((rx_done && rx_err) || (rx_done && prev_done) || (rx_err && prev_err))
            viol <= viol + 1;
        prev_done <= rx_done;
        prev_err  <= rx_err;
    end

    // Drive one 8N1 frame, p clocks per bit, starting at the current negedge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int p,
                              input int chg_bit, input logic [16:0] chg_baud,
                              output int start_cyc, output int busy_cyc);
        logic [9:0] bits;
        bits      = {stop, d, 1'b0};
        busy_cyc  = 0;
        start_cyc = cyc;
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            if (b == chg_bit) baud = chg_baud;
            for (int i = 0; i < p; i++) begin
                @(negedge clk);
                if (busy) busy_cyc++;
            end
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        rx   = 1'b1;
        baud = 17'd57600;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_done !== 1'b0) begin failures++; $display("FAIL reset_rx_done got=%b exp=0", rx_done); end
        checks++; if (rx_err !== 1'b0) begin failures++; $display("FAIL reset_rx_err got=%b exp=0", rx_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // 0xA5 at 57600 with baud switched to 4800 mid-frame; P stays 868.
    task automatic test_single_frame;
        int d0, e0, sc, bc, diff;
        d0 = done_cnt; e0 = err_cnt;
        baud = 17'd57600;
        send_frame(8'hA5, 1'b1, 868, 3, 17'd4800, sc, bc);
        baud = 17'd57600;
        repeat (2) @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL single_err_count got=%0d exp=0", err_cnt - e0); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL single_rx_data got=%h exp=a5", rx_data); end
        checks++; if (bc !== 434 + 9 * 868) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=%0d", bc, 434 + 9 * 868); end
        diff = last_done_cyc - sc - (SYNC + 1 + 434 + 9 * 868);
        checks++; if (diff < -1 || diff > 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", last_done_cyc - sc, SYNC + 1 + 434 + 9 * 868); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy); end
        $display("frame A5 @57600 (baud->4800 mid-frame): rx_data=%h busy_cycles=%0d", rx_data, bc);
    endtask

    task automatic test_back_to_back;
        int d0, sc, bc, t1, diff;
        d0 = done_cnt;
        baud = 17'd57600;
        send_frame(8'h3C, 1'b1, 868, -1, 17'd0, sc, bc);
        t1 = last_done_cyc;
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL b2b_first_data got=%h exp=3c", rx_data); end
        send_frame(8'hFF, 1'b1, 868, -1, 17'd0, sc, bc);
        repeat (2) @(negedge clk);
        checks++; if (rx_data !== 8'hFF) begin failures++; $display("FAIL b2b_second_data got=%h exp=ff", rx_data); end
        checks++; if (done_cnt - d0 !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0); end
        diff = last_done_cyc - t1 - 8680;
        checks++; if (diff < -1 || diff > 1) begin failures++; $display("FAIL b2b_spacing got=%0d exp=8680", last_done_cyc - t1); end
        $display("back-to-back 3C,FF @57600: spacing=%0d", last_done_cyc - t1);
    endtask

    // Short low pulse: busy must stay high exactly H cycles, with no strobes.
    task automatic test_glitch(input logic [16:0] b, input int h, input int glen);
        int bc, d0, e0;
        bc = 0; d0 = done_cnt; e0 = err_cnt;
        baud = b;
        @(negedge clk);
        rx = 1'b0;
        for (int i = 0; i < h + 50; i++) begin
            @(negedge clk);
            if (i == glen - 1) rx = 1'b1;
            if (busy) bc++;
        end
        checks++; if (bc !== h) begin failures++; $display("FAIL glitch_busy_len baud=%0d got=%0d exp=%0d", b, bc, h); end
        checks++; if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin failures++; $display("FAIL glitch_pulses baud=%0d got=%0d exp=0", b, (done_cnt - d0) + (err_cnt - e0)); end
        $display("false start baud=%0d: busy_cycles=%0d", b, bc);
    endtask

    task automatic test_false_start;
        test_glitch(17'd4800,  5208, 200);
        test_glitch(17'd9600,  2604, 1000);
        test_glitch(17'd14400, 1736, 200);
        test_glitch(17'd19200, 1302, 200);
        test_glitch(17'd38400, 651,  200);
        test_glitch(17'd57600, 434,  200);
        test_glitch(17'd12345, 2604, 200);
    endtask

    task automatic test_framing_error;
        int d0, e0, sc, bc;
        d0 = done_cnt; e0 = err_cnt;
        baud = 17'd57600;
        send_frame(8'h55, 1'b0, 868, -1, 17'd0, sc, bc);
        repeat (3 * 868) @(negedge clk);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL ferr_err_count got=%0d exp=1", err_cnt - e0); end
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL ferr_done_count got=%0d exp=0", done_cnt - d0); end
        checks++; if (rx_data !== 8'hFF) begin failures++; $display("FAIL ferr_rx_data_kept got=%h exp=ff", rx_data); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_busy_in_break got=%b exp=1", busy); end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy_release got=%b exp=0", busy); end
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL ferr_single_err got=%0d exp=1", err_cnt - e0); end
        send_frame(8'h12, 1'b1, 868, -1, 17'd0, sc, bc);
        repeat (2) @(negedge clk);
        checks++; if (rx_data !== 8'h12) begin failures++; $display("FAIL ferr_next_data got=%h exp=12", rx_data); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ferr_next_done got=%0d exp=1", done_cnt - d0); end
        $display("framing error 55 + break, then 12: rx_data=%h", rx_data);
    endtask

    task automatic test_async_reset;
        int d0, e0, sc, bc;
        logic [9:0] bits;
        d0 = done_cnt; e0 = err_cnt;
        baud = 17'd57600;
        bits = {1'b1, 8'h99, 1'b0};
        for (int b = 0; b < 6; b++) begin
            rx = bits[b];
            repeat ((b == 5) ? 434 : 868) @(negedge clk);
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL arst_busy_before got=%b exp=1", busy); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL arst_rx_data got=%h exp=00", rx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
        checks++; if (rx_done !== 1'b0 || rx_err !== 1'b0) begin failures++; $display("FAIL arst_pulses got=%b%b exp=00", rx_done, rx_err); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * 868) @(negedge clk);
        checks++; if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin failures++; $display("FAIL arst_aborted_pulses got=%0d exp=0", (done_cnt - d0) + (err_cnt - e0)); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_idle_busy got=%b exp=0", busy); end
        send_frame(8'h7E, 1'b1, 868, -1, 17'd0, sc, bc);
        repeat (2) @(negedge clk);
        checks++; if (rx_data !== 8'h7E) begin failures++; $display("FAIL arst_next_data got=%h exp=7e", rx_data); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL arst_next_done got=%0d exp=1", done_cnt - d0); end
        $display("async reset mid-frame, then 7E: rx_data=%h", rx_data);
    endtask

    task automatic test_pulse_rules;
        checks++; if (viol !== 0) begin failures++; $display("FAIL pulse_rules got=%0d exp=0", viol); end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_false_start;
        test_framing_error;
        test_async_reset;
        test_pulse_rules;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
